// File: rtl/matrix_loader.sv
// matrix_loader
//
// Upstream feeder for the flat-bus matrix operation stage. It takes a serial
// stream of elements over a valid/ready handshake: matrix A first, then
// matrix B, each in row-major order. Each matrix is packed into a flat bus.
// Element (i,j) sits at bits [length*(size*i+j+1)-1 : length*(size*i+j)].
// The completed pair is presented downstream and held stable until it is
// taken.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   flush      synchronous frame abort (present only with MATRIX_LOADER_FLUSH_EN)
//   in_data    element value
//   in_valid   in_data is valid this cycle
//   in_last    marks the final element of matrix B
//   in_ready   an element is accepted this cycle if in_valid is high
//   first      assembled matrix A
//   second     assembled matrix B
//   out_valid  first/second hold a complete pair
//   out_ready  downstream takes the pair
//   err        sticky framing error
//
// Optional feature: define MATRIX_LOADER_FLUSH_EN to add the flush input.

module matrix_loader #(
    parameter int unsigned size   = 2,
    parameter int unsigned length = 8
) (
    input  logic                          clk,
    input  logic                          rst,
`ifdef MATRIX_LOADER_FLUSH_EN
    input  logic                          flush,
`endif
    input  logic [length-1:0]             in_data,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          in_ready,
    output logic [size*size*length-1:0]   first,
    output logic [size*size*length-1:0]   second,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          err
);

    localparam int unsigned Elems = size * size;
    localparam int unsigned IdxW  = (Elems > 1) ? $clog2(Elems) : 1;
    localparam int unsigned BusW  = Elems * length;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(Elems - 1);

    typedef enum logic [1:0] {
        StLoadA,
        StLoadB,
        StFull
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [BusW-1:0]   first_q, first_d;
    logic [BusW-1:0]   second_q, second_d;
    logic              out_valid_q, out_valid_d;
    logic              err_q, err_d;
    logic              accept;
    logic              last_slot;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        first_d     = first_q;
        second_d    = second_q;
        out_valid_d = out_valid_q;
        err_d       = err_q;

        in_ready = (state_q != StFull);
`ifdef MATRIX_LOADER_FLUSH_EN
        // Flush wins over any element offered in the same cycle.
        if (flush) begin
            in_ready = 1'b0;
        end
`endif
        accept    = in_valid && in_ready;
        last_slot = (idx_q == LastIdx);

        case (state_q)
            StLoadA: begin
                if (accept) begin
                    first_d[int'(idx_q)*length +: length] = in_data;
                    if (in_last) begin
                        // Early end-of-frame: keep the write, drop the frame.
                        err_d = 1'b1;
                        idx_d = '0;
                    end else if (last_slot) begin
                        idx_d   = '0;
                        state_d = StLoadB;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            StLoadB: begin
                if (accept) begin
                    second_d[int'(idx_q)*length +: length] = in_data;
                    if (last_slot) begin
                        // Missing in_last is flagged but the pair still completes.
                        if (!in_last) begin
                            err_d = 1'b1;
                        end
                        idx_d       = '0;
                        state_d     = StFull;
                        out_valid_d = 1'b1;
                    end else if (in_last) begin
                        err_d   = 1'b1;
                        idx_d   = '0;
                        state_d = StLoadA;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            StFull: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StLoadA;
                end
            end
            default: begin
                state_d     = StLoadA;
                idx_d       = '0;
                out_valid_d = 1'b0;
            end
        endcase

`ifdef MATRIX_LOADER_FLUSH_EN
        // Data buses keep their contents; only control state is cleared.
        if (flush) begin
            state_d     = StLoadA;
            idx_d       = '0;
            out_valid_d = 1'b0;
            err_d       = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StLoadA;
            idx_q       <= '0;
            first_q     <= '0;
            second_q    <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            first_q     <= first_d;
            second_q    <= second_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign first     = first_q;
    assign second    = second_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Testbench for matrix_loader (size=2, length=8).
// Stimulus pushes each expected {first, second} pair into a queue. A monitor
// pops a pair when out_valid rises. It then compares the buses on every cycle
// that out_valid stays high.

module tb_matrix_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush = 1'b0;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] first;
    logic [31:0] second;
    logic        out_valid;
    logic        out_ready;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] exp_q[$];
    logic [63:0] cur_pair = '0;
    logic        prev_valid = 1'b0;

    always #5 clk = ~clk;

    matrix_loader #(
        .size   (2),
        .length (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef MATRIX_LOADER_FLUSH_EN
        .flush     (flush),
`endif
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .first     (first),
        .second    (second),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: sample away from the active edge.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (!prev_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out_valid: got pair %h_%h, expected none",
                             first, second);
                end else begin
                    cur_pair = exp_q.pop_front();
                end
            end
            check("pair_first", {32'h0, first}, {32'h0, cur_pair[63:32]});
            check("pair_second", {32'h0, second}, {32'h0, cur_pair[31:0]});
        end
        prev_valid = (out_valid === 1'b1);
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic send(input logic [7:0] d, input logic l, input bit gap);
        check("in_ready_before_accept", {63'h0, in_ready}, 64'h1);
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(input logic [31:0] a, input logic [31:0] b, input bit gap,
                         input bit mark_last);
        exp_q.push_back({a, b});
        for (int k = 0; k < 4; k++) begin
            send(a[8*k +: 8], 1'b0, gap);
        end
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                check("out_valid_before_last", {63'h0, out_valid}, 64'h0);
            end
            send(b[8*k +: 8], mark_last && (k == 3), gap);
        end
        if (gap) begin
            // The trailing idle cycle already passed; out_valid must still be up.
            check("out_valid_after_gap", {63'h0, out_valid}, 64'h1);
        end else begin
            check("out_valid_latency", {63'h0, out_valid}, 64'h1);
        end
        check("in_ready_full", {63'h0, in_ready}, 64'h0);
    endtask

    task automatic take(input int stall);
        repeat (stall) begin
            @(posedge clk);
            #1;
        end
        check("in_ready_stalled", {63'h0, in_ready}, 64'h0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_after_take", {63'h0, out_valid}, 64'h0);
        check("in_ready_after_take", {63'h0, in_ready}, 64'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        @(negedge clk);
        check("rst_first", {32'h0, first}, 64'h0);
        check("rst_second", {32'h0, second}, 64'h0);
        check("rst_out_valid", {63'h0, out_valid}, 64'h0);
        check("rst_err", {63'h0, err}, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("in_ready_after_rst", {63'h0, in_ready}, 64'h1);

        // Basic frame; the pair is held for 5 stall cycles before the handoff.
        frame(32'h04030201, 32'h40302010, 1'b0, 1'b1);
        check("err_clean_frame", {63'h0, err}, 64'h0);
        take(5);

        // Every slot is overwritten by the next frame.
        frame(32'hA4A3A2A1, 32'hB4B3B2B1, 1'b0, 1'b1);
        take(0);

        // in_valid toggles 1/0 every cycle.
        frame(32'hC4C3C2C1, 32'hD4D3D2D1, 1'b1, 1'b1);
        take(1);

        // Early in_last on A slot 2 drops the frame and sets err.
        send(8'h01, 1'b0, 1'b0);
        send(8'h02, 1'b0, 1'b0);
        send(8'h03, 1'b1, 1'b0);
        check("err_early_last", {63'h0, err}, 64'h1);
        check("out_valid_dropped", {63'h0, out_valid}, 64'h0);
        check("in_ready_dropped", {63'h0, in_ready}, 64'h1);
        frame(32'hE4E3E2E1, 32'hF4F3F2F1, 1'b0, 1'b1);
        check("err_sticky", {63'h0, err}, 64'h1);
        take(0);

        // Asynchronous reset after 5 accepts, in the middle of a cycle.
        for (int k = 0; k < 5; k++) begin
            send(8'h50 + 8'(k), 1'b0, 1'b0);
        end
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_first", {32'h0, first}, 64'h0);
        check("async_rst_second", {32'h0, second}, 64'h0);
        check("async_rst_out_valid", {63'h0, out_valid}, 64'h0);
        check("async_rst_err", {63'h0, err}, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("in_ready_after_async_rst", {63'h0, in_ready}, 64'h1);
        frame(32'h44332211, 32'h88776655, 1'b0, 1'b1);
        check("err_after_rst_frame", {63'h0, err}, 64'h0);
        take(0);

        // Missing in_last on the final B element: err is set, the frame completes.
        frame(32'h0D0C0B0A, 32'h1D1C1B1A, 1'b0, 1'b0);
        check("err_missing_last", {63'h0, err}, 64'h1);
        take(0);

`ifdef MATRIX_LOADER_FLUSH_EN
        // Flush after 3 accepts with in_valid held high.
        send(8'h61, 1'b0, 1'b0);
        send(8'h62, 1'b0, 1'b0);
        send(8'h63, 1'b0, 1'b0);
        in_data  = 8'hFF;
        in_valid = 1'b1;
        flush    = 1'b1;
        #1;
        check("in_ready_during_flush", {63'h0, in_ready}, 64'h0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("err_after_flush", {63'h0, err}, 64'h0);
        check("out_valid_after_flush", {63'h0, out_valid}, 64'h0);
        check("in_ready_after_flush", {63'h0, in_ready}, 64'h1);
        frame(32'h74737271, 32'h84838281, 1'b0, 1'b1);
        check("err_flush_frame", {63'h0, err}, 64'h0);
        take(0);
`endif

        @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_loader.md
Name: matrix_loader

Overview:
- Upstream feeder for the flat-bus matrix operation stage.
- Accepts a serial stream of `length`-bit elements over a valid/ready handshake. Matrix A arrives first, then matrix B, each in row-major order.
- Assembles both into packed buses of size*size*length bits. Element (i,j) occupies bits [length*(size*i+j+1)-1 : length*(size*i+j)].
- Presents the pair downstream with out_valid/out_ready and holds it stable until taken.

Parameters:
- size, 2, matrix dimension (size x size); legal range 1..8.
- length, 8, element width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_data  input  length  element value.
- in_valid  input  1  in_data is valid this cycle.
- in_last  input  1  marks the final element of matrix B.
- in_ready  output  1  loader accepts an element this cycle.
- first  output  size*size*length  assembled matrix A.
- second  output  size*size*length  assembled matrix B.
- out_valid  output  1  first/second hold a complete pair.
- out_ready  input  1  downstream takes the pair.
- err  output  1  sticky framing error.

Behaviour:
- Reset (async, while rst=1):
  - state=LOAD_A, idx=0.
  - first=0, second=0, out_valid=0, err=0.
  - in_ready=1 in the first cycle after rst deasserts.
- Accept: an element is accepted on a rising edge where in_valid && in_ready.
- in_ready = (state != FULL); it is combinational from state only.
- idx counts 0..size*size-1 and selects the destination slot. All other slots are unchanged.
- LOAD_A:
  - Each accept writes in_data to slot idx of first.
  - At idx=size*size-1: idx->0, state->LOAD_B; otherwise idx+1.
- LOAD_B:
  - Each accept writes in_data to slot idx of second.
  - At idx=size*size-1: state->FULL, idx->0.
- FULL:
  - out_valid=1 (registered; high the cycle after the last B element is accepted, i.e. 1-cycle latency).
  - first/second are stable. in_ready=0.
  - On out_ready=1: out_valid->0 and state->LOAD_A at that edge.
  - No element is accepted in the same cycle as the handoff. Max throughput is one pair per 2*size*size+1 cycles.
- in_last framing:
  - in_last is sampled only on accepted elements.
  - in_last=1 on any element other than B slot size*size-1: the element is written, err->1, the frame is dropped (state->LOAD_A, idx->0), and out_valid is not raised.
  - in_last=0 on B slot size*size-1: err->1, but the frame still completes (FULL, out_valid=1).
  - err is sticky; it clears only on rst (or flush, see below).
- Data contents are not cleared between frames; every slot is overwritten by the next complete frame.
- in_valid=0 stalls loading indefinitely with no state change.
- rst asserted mid-frame or while FULL: immediate return to reset values; the partial frame is lost.
- No arithmetic; data is passed through bit-exact. idx width is clog2(size*size), minimum 1 bit.

Optional Feature:
- Macro MATRIX_LOADER_FLUSH_EN.
- Defined:
  - Adds input port `flush` (1 bit, synchronous, active-high).
  - On a rising edge with flush=1: state->LOAD_A, idx->0, out_valid->0, err->0. first/second keep their contents.
  - flush has priority over any accept or out_ready in the same cycle; the element offered that cycle is not accepted (in_ready is forced 0 while flush=1).
- Not defined: no flush port. Recovery from a partial frame is by rst only.

Test Plan (size=2, length=8):
- Load A = 01,02,03,04, then B = 10,20,30,40 with in_last on 40, out_ready=0 -> one cycle after the 40 accept: out_valid=1, first=32'h04030201, second=32'h40302010, in_ready=0. Both buses are held for 5 stall cycles.
- In FULL, pulse out_ready=1 for one cycle -> next cycle: out_valid=0, in_ready=1. A second frame of 8 elements produces new values in all slots.
- in_valid toggled 1/0 every cycle during loading -> only valid cycles advance idx. out_valid rises exactly one cycle after the 8th accepted element.
- Assert in_last on the 3rd element (A slot 2) -> err=1, no out_valid. The next 8 elements with correct in_last form a valid frame; err stays 1.
- Assert rst asynchronously after 5 accepts -> first=second=0, out_valid=0, err=0 immediately. The following 8-element frame completes normally.
- MATRIX_LOADER_FLUSH_EN defined: flush after 3 accepts with in_valid=1 held -> that element is not accepted, idx=0, err=0. The next 8 accepts produce a correct pair.
